// File: rtl/uart_rx.sv
// uart_rx: UART receiver for the board serial link.
// Recovers start / data (LSB first) / optional parity / stop frames from the
// asynchronous rx_i line by mid-bit sampling. It hands each word, with its
// parity and framing error flags, to the consumer over a valid/yumi handshake.
// Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3
// vote over the samples at mid-1, mid and mid+1. This moves completion one
// cycle later.
module uart_rx #(
  parameter int clk_per_bit_p = 10416,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   rx_i,
  output logic                   rx_v_o,
  output logic [data_bits_p-1:0] rx_o,
  output logic                   rx_parity_err_o,
  output logic                   rx_frame_err_o,
  input  logic                   rx_yumi_i,
  output logic                   rx_overrun_o
);

  localparam int cnt_w_lp = (clk_per_bit_p + 1 > 2) ? $clog2(clk_per_bit_p + 1) : 1;
  localparam int bit_w_lp = (data_bits_p > 1) ? $clog2(data_bits_p) : 1;

  // Cycle within the start bit at which the start decision is made. It is
  // mid-bit, or one cycle later when the decision waits for the third vote.
  // After that decision, every later bit is decided one full bit period on.
`ifdef UART_RX_MAJORITY_EN
  localparam int start_samp_lp = clk_per_bit_p / 2;
`else
  localparam int start_samp_lp = clk_per_bit_p / 2 - 1;
`endif

  localparam logic [cnt_w_lp-1:0] start_samp_c = cnt_w_lp'(start_samp_lp);
  localparam logic [cnt_w_lp-1:0] bit_samp_c   = cnt_w_lp'(clk_per_bit_p - 1);
  localparam logic [bit_w_lp-1:0] last_data_c  = bit_w_lp'(data_bits_p - 1);
  localparam logic [bit_w_lp-1:0] last_stop_c  = bit_w_lp'(stop_bits_p - 1);

  typedef enum logic [2:0] {
    e_reset,
    e_idle,
    e_start_bit,
    e_data_bits,
    e_parity_bit,
    e_stop_bit
  } state_e;

  state_e                 state_reg, state_next;
  logic [cnt_w_lp-1:0]    clk_cnt_reg, clk_cnt_next;
  logic [bit_w_lp-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [data_bits_p-1:0] shift_reg, shift_next;
  logic                   perr_acc_reg, perr_acc_next;
  logic                   ferr_acc_reg, ferr_acc_next;
  logic                   frame_done;
  logic                   done_ferr;

  logic                   rx_meta_reg, rxs_reg;
  logic [1:0]             sync_fill_reg;
  logic                   bit_val;

  logic                   rx_v_reg;
  logic [data_bits_p-1:0] rx_data_reg;
  logic                   rx_perr_reg;
  logic                   rx_ferr_reg;
  logic                   rx_overrun_reg;

  // Two-flop synchronizer. sync_fill_reg records when rxs_reg carries a real
  // line sample rather than its reset value, so a line held low through reset
  // is not mistaken for idle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_meta_reg   <= 1'b1;
      rxs_reg       <= 1'b1;
      sync_fill_reg <= 2'b00;
    end else begin
      rx_meta_reg   <= rx_i;
      rxs_reg       <= rx_meta_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  // The last two synchronized samples. At the decision cycle they are mid-1
  // and mid, and the current rxs_reg is mid+1.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rxs_reg};
    end
  end

  assign bit_val = (hist_reg[1] & hist_reg[0]) |
                   (hist_reg[1] & rxs_reg) |
                   (hist_reg[0] & rxs_reg);
`else
  assign bit_val = rxs_reg;
`endif

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg    <= e_reset;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      perr_acc_reg <= 1'b0;
      ferr_acc_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      perr_acc_reg <= perr_acc_next;
      ferr_acc_reg <= ferr_acc_next;
    end
  end

  // Next-state logic. Bit timing is counted from the start decision, so each
  // later decision lands at the same point inside its bit.
  always_comb begin
    state_next    = state_reg;
    clk_cnt_next  = clk_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    perr_acc_next = perr_acc_reg;
    ferr_acc_next = ferr_acc_reg;
    frame_done    = 1'b0;
    done_ferr     = ferr_acc_reg;

    case (state_reg)
      e_reset: begin
        clk_cnt_next = '0;
        if (sync_fill_reg[1] && rxs_reg) begin
          state_next = e_idle;
        end
      end

      e_idle: begin
        clk_cnt_next  = '0;
        bit_cnt_next  = '0;
        perr_acc_next = 1'b0;
        ferr_acc_next = 1'b0;
        if (!rxs_reg) begin
          state_next = e_start_bit;
        end
      end

      e_start_bit: begin
        if (clk_cnt_reg == start_samp_c) begin
          clk_cnt_next = '0;
          // A start bit that reads high at mid-bit was a glitch; drop it.
          state_next   = bit_val ? e_idle : e_data_bits;
        end
      end

      e_data_bits: begin
        if (clk_cnt_reg == bit_samp_c) begin
          clk_cnt_next = '0;
          shift_next   = {bit_val, shift_reg[data_bits_p-1:1]};
          if (bit_cnt_reg == last_data_c) begin
            bit_cnt_next = '0;
            state_next   = (parity_bit_p != 0) ? e_parity_bit : e_stop_bit;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      e_parity_bit: begin
        if (clk_cnt_reg == bit_samp_c) begin
          clk_cnt_next  = '0;
          perr_acc_next = ((^shift_reg) ^ bit_val) ^ (parity_odd_p != 0);
          state_next    = e_stop_bit;
        end
      end

      e_stop_bit: begin
        if (clk_cnt_reg == bit_samp_c) begin
          clk_cnt_next  = '0;
          ferr_acc_next = ferr_acc_reg | ~bit_val;
          if (bit_cnt_reg == last_stop_c) begin
            // Complete at the last stop decision. Not waiting for the end of
            // the stop bit lets a back-to-back start edge be caught.
            frame_done = 1'b1;
            done_ferr  = ferr_acc_reg | ~bit_val;
            state_next = e_idle;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = e_reset;
      end
    endcase
  end

  // Output holding register. The held word stays until the consumer takes it.
  // A frame that completes while the word is held and not taken is dropped and
  // reported by a one-cycle overrun pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_v_reg       <= 1'b0;
      rx_data_reg    <= '0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_overrun_reg <= 1'b0;
      if (frame_done) begin
        if (rx_v_reg && !rx_yumi_i) begin
          rx_overrun_reg <= 1'b1;
        end else begin
          rx_v_reg    <= 1'b1;
          rx_data_reg <= shift_reg;
          rx_perr_reg <= perr_acc_reg;
          rx_ferr_reg <= done_ferr;
        end
      end else if (rx_yumi_i) begin
        rx_v_reg <= 1'b0;
      end
    end
  end

  assign rx_v_o          = rx_v_reg;
  assign rx_o            = rx_data_reg;
  assign rx_parity_err_o = rx_perr_reg;
  assign rx_frame_err_o  = rx_ferr_reg;
  assign rx_overrun_o    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames into two receivers sharing one clock.
// The first receiver is 8N1 and the second is 8E2 (even parity, two stops).
// Expected words and flags come from the frame contents the bench chose.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       rx_a, rx_b;
  logic       yumi_a, yumi_b;
  logic       v_a, v_b;
  logic [7:0] d_a, d_b;
  logic       pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt_a = 0;
  int ov_cnt_b = 0;

  uart_rx #(.clk_per_bit_p(CPB), .data_bits_p(8), .parity_bit_p(0),
            .parity_odd_p(0), .stop_bits_p(1)) u_dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx_a),
    .rx_v_o(v_a), .rx_o(d_a), .rx_parity_err_o(pe_a), .rx_frame_err_o(fe_a),
    .rx_yumi_i(yumi_a), .rx_overrun_o(ov_a)
  );

  uart_rx #(.clk_per_bit_p(CPB), .data_bits_p(8), .parity_bit_p(1),
            .parity_odd_p(0), .stop_bits_p(2)) u_dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx_b),
    .rx_v_o(v_b), .rx_o(d_b), .rx_parity_err_o(pe_b), .rx_frame_err_o(fe_b),
    .rx_yumi_i(yumi_b), .rx_overrun_o(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count overrun pulses; each pulse is one cycle wide, so it is seen once.
  always @(negedge clk) begin
    if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
    if (ov_b) ov_cnt_b <= ov_cnt_b + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Edge index (counted from the edge that first samples the start bit) at
  // which rx_v_o becomes high for a frame of nbits bits. The last stop bit is
  // sampled CPB/2 cycles into that bit, then passes two synchronizer flops and
  // the output register. The vote adds one cycle.
  function automatic int done_edge(input int nbits);
    return (nbits - 1) * CPB + CPB / 2 + 2 + VOTE_DLY;
  endfunction

  // Even parity: the data ones plus the parity bit must total an even count.
  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) != 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic set_yumi(input int sel, input logic v);
    if (sel == 0) yumi_a = v; else yumi_b = v;
  endtask

  // One bit period. Entry is at a negedge; the optional glitch flips the
  // line for the single cycle that is sampled at mid-bit.
  task automatic drive_bit(input int sel, input logic v, input logic glitch);
    for (int c = 0; c < CPB; c++) begin
      set_line(sel, (glitch && c == CPB / 2) ? ~v : v);
      @(negedge clk);
    end
  endtask

  // glitch_idx: 0 = start bit, 1..8 = data bits, -1 = none.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input int glitch_idx);
    drive_bit(sel, 1'b0, glitch_idx == 0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i], glitch_idx == i + 1);
    if (sel == 1) drive_bit(sel, pbit, 1'b0);
    drive_bit(sel, stops[0], 1'b0);
    if (sel == 1) drive_bit(sel, stops[1], 1'b0);
    set_line(sel, 1'b1);
  endtask

  task automatic expect_word(input int sel, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
    if (sel == 0) begin
      check({tag, ".v"}, v_a, 1);
      check({tag, ".data"}, d_a, d);
      check({tag, ".perr"}, pe_a, pe);
      check({tag, ".ferr"}, fe_a, fe);
    end else begin
      check({tag, ".v"}, v_b, 1);
      check({tag, ".data"}, d_b, d);
      check({tag, ".perr"}, pe_b, pe);
      check({tag, ".ferr"}, fe_b, fe);
    end
    $display("frame dut=%0d tag=%s data=%02h perr=%0d ferr=%0d", sel, tag, d, pe, fe);
  endtask

  // Accept the held word with a one-cycle yumi and confirm valid drops.
  task automatic accept(input int sel, input string tag);
    set_yumi(sel, 1'b1);
    @(negedge clk);
    set_yumi(sel, 1'b0);
    check({tag, ".v_clear"}, (sel == 0) ? v_a : v_b, 0);
  endtask

  initial begin
    int         seen;
    int         ov0;
    int         sel;
    int         gap;
    logic [7:0] d;
    logic       pbit;
    logic [1:0] st;

    reset_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    yumi_a = 1'b0; yumi_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state: every output low.
    check("rst.v_a", v_a, 0);   check("rst.d_a", d_a, 0);
    check("rst.pe_a", pe_a, 0); check("rst.fe_a", fe_a, 0);
    check("rst.ov_a", ov_a, 0);
    check("rst.v_b", v_b, 0);   check("rst.d_b", d_b, 0);
    check("rst.pe_b", pe_b, 0); check("rst.fe_b", fe_b, 0);
    check("rst.ov_b", ov_b, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0x55: exact valid timing, yumi on the first valid cycle.
    fork
      send_frame(0, 8'h55, 1'b0, 2'b11, -1);
      begin
        repeat (done_edge(10)) @(negedge clk);
        check("t1.v_early", v_a, 0);
        @(negedge clk);
        expect_word(0, "t1", 8'h55, 1'b0, 1'b0);
        yumi_a = 1'b1;
        @(negedge clk);
        yumi_a = 1'b0;
        check("t1.v_one_cycle", v_a, 0);
      end
    join
    repeat (4) @(negedge clk);

    // Even parity: 0xA7 has five ones, so parity bit 1 is correct and 0 is not.
    fork
      send_frame(1, 8'hA7, 1'b1, 2'b11, -1);
      begin
        repeat (done_edge(12)) @(negedge clk);
        check("t2.v_early", v_b, 0);
        @(negedge clk);
        check("t2.v_on_time", v_b, 1);
      end
    join
    expect_word(1, "t2.good", 8'hA7, 1'b0, 1'b0);
    accept(1, "t2.good");
    send_frame(1, 8'hA7, 1'b0, 2'b11, -1);
    expect_word(1, "t2.bad", 8'hA7, 1'b1, 1'b0);
    accept(1, "t2.bad");

    // Four-cycle low pulse: false start, nothing delivered, still idle after.
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    seen = 0;
    for (int c = 0; c < 3 * CPB; c++) begin
      @(negedge clk);
      if (v_a || ov_a || pe_a || fe_a) seen++;
    end
    check("t3.no_output", seen, 0);
    send_frame(0, 8'hC3, 1'b0, 2'b11, -1);
    expect_word(0, "t3.after", 8'hC3, 1'b0, 1'b0);
    accept(0, "t3.after");

    // Low stop bit: word still delivered, flagged. Idle line follows it.
    send_frame(1, 8'h3C, 1'b0, 2'b01, -1);
    repeat (2 * CPB) @(negedge clk);
    expect_word(1, "t4.b", 8'h3C, 1'b0, 1'b1);
    accept(1, "t4.b");
    send_frame(0, 8'h3C, 1'b0, 2'b10, -1);
    repeat (2 * CPB) @(negedge clk);
    expect_word(0, "t4.a", 8'h3C, 1'b0, 1'b1);
    accept(0, "t4.a");

    // Back-to-back with no yumi: second frame dropped, one overrun pulse.
    ov0 = ov_cnt_a;
    send_frame(0, 8'h11, 1'b0, 2'b11, -1);
    send_frame(0, 8'h22, 1'b0, 2'b11, -1);
    repeat (2) @(negedge clk);
    expect_word(0, "t5.keep", 8'h11, 1'b0, 1'b0);
    check("t5.one_overrun", ov_cnt_a - ov0, 1);
    accept(0, "t5.keep");

    // Back-to-back with yumi on the second completion cycle: new word, no overrun.
    ov0 = ov_cnt_a;
    fork
      begin
        send_frame(0, 8'h11, 1'b0, 2'b11, -1);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1);
      end
      begin
        repeat (10 * CPB + done_edge(10)) @(negedge clk);
        yumi_a = 1'b1;
        @(negedge clk);
        yumi_a = 1'b0;
        check("t5.swap_v", v_a, 1);
        check("t5.swap_data", d_a, 8'h22);
      end
    join
    repeat (2) @(negedge clk);
    check("t5.no_overrun", ov_cnt_a - ov0, 0);
    accept(0, "t5.swap");

    // Reset during data bit 3 of an all-low line: the held word is discarded,
    // and no frame appears until the line returns high.
    send_frame(0, 8'h5A, 1'b0, 2'b11, -1);
    check("t6.held", v_a, 1);
    rx_a = 1'b0;
    repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6.discard", v_a, 0);
    seen = 0;
    for (int c = 0; c < 25 * CPB; c++) begin
      @(negedge clk);
      if (v_a || ov_a) seen++;
    end
    check("t6.no_frame_low", seen, 0);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(0, 8'h96, 1'b0, 2'b11, -1);
    expect_word(0, "t6.clean", 8'h96, 1'b0, 1'b0);
    accept(0, "t6.clean");

`ifdef UART_RX_MAJORITY_EN
    // A single-cycle glitch at mid-bit is outvoted (data bit 2 and start bit).
    send_frame(0, 8'h96, 1'b0, 2'b11, 3);
    expect_word(0, "t6.glitch_data", 8'h96, 1'b0, 1'b0);
    accept(0, "t6.glitch_data");
    send_frame(0, 8'h69, 1'b0, 2'b11, 0);
    expect_word(0, "t6.glitch_start", 8'h69, 1'b0, 1'b0);
    accept(0, "t6.glitch_start");
`endif

    // Random frames with occasional parity and stop-bit corruption.
    for (int k = 0; k < 24; k++) begin
      sel  = $urandom_range(0, 1);
      d    = 8'($urandom);
      pbit = (($countones(d) % 2) != 0) ^ ($urandom_range(0, 3) == 0);
      st[0] = ($urandom_range(0, 5) != 0);
      st[1] = ($urandom_range(0, 5) != 0);
      if (sel == 0) st[1] = 1'b1;
      gap = (st != 2'b11) ? CPB + $urandom_range(0, 8) : $urandom_range(0, 8);
      send_frame(sel, d, pbit, st, -1);
      repeat (gap) @(negedge clk);
      if (sel == 0)
        expect_word(0, "rnd", d, 1'b0, !st[0]);
      else
        expect_word(1, "rnd", d, exp_perr(d, pbit), !(st[0] && st[1]));
      accept(sel, "rnd");
    end

    repeat (4) @(negedge clk);
    check("end.ov_b_none", ov_cnt_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
